// File: rtl/pq_controller.sv
// Sorted BRAM priority-queue sequencer: descending order, largest key at address 0.
// Latency: enqueue busy 2*n+1 cycles, dequeue busy 2*n cycles (n = entries before the op); deq_valid 2 cycles after accept.
// Backpressure: enq_ready drops while busy or full; deq_req is only sampled in IDLE and wins over a same-cycle enqueue.
module pq_controller #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enq_valid,
    input  logic [WIDTH-1:0]  enq_data,
    output logic              enq_ready,
    input  logic              deq_req,
    output logic              deq_valid,
    output logic [WIDTH-1:0]  deq_data,
    output logic              deq_err,
    output logic              busy,
    output logic              op_done,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ENQ_RD,
        ENQ_CMP,
        ENQ_WR,
        DEQ_HEAD,
        DEQ_CAP,
        DEQ_RD,
        DEQ_SH
    } state_t;

    localparam logic [ADDR_W:0]   ONE_C  = 1;
    localparam logic [ADDR_W-1:0] ONE_A  = 1;
    localparam logic [ADDR_W:0]   FULL_C = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   idx;
    logic [WIDTH-1:0]  carry;

    logic [ADDR_W:0]   idx_nxt;
    logic [ADDR_W-1:0] idx_prev;
    logic              swap;

    assign idx_nxt  = idx + ONE_C;
    // idx is always >= 1 in DEQ_SH, so the low bits minus one never wrap.
    assign idx_prev = idx[ADDR_W-1:0] - ONE_A;
    // Strict compare: an incoming key never overtakes an equal stored key.
    assign swap     = carry > mem_rdata;

    assign full      = (count == FULL_C);
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);
    assign enq_ready = (state == IDLE) && !full;

    // BRAM port decode: read address when not writing, write carry or shifted entry otherwise.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = carry;
        case (state)
            ENQ_RD: begin
                mem_addr = idx[ADDR_W-1:0];
            end
            ENQ_CMP: begin
                mem_addr = idx[ADDR_W-1:0];
                mem_we   = swap;
            end
            ENQ_WR: begin
                mem_addr = count[ADDR_W-1:0];
                mem_we   = 1'b1;
            end
            DEQ_RD: begin
                mem_addr = idx[ADDR_W-1:0];
            end
            DEQ_SH: begin
                mem_addr  = idx_prev;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata;
            end
            default: begin
            end
        endcase
    end

    // Sequencing FSM with occupancy counter, popped-key register and single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= '0;
            count     <= '0;
            deq_data  <= '0;
            deq_valid <= 1'b0;
            deq_err   <= 1'b0;
            op_done   <= 1'b0;
        end else begin
            deq_valid <= 1'b0;
            deq_err   <= 1'b0;
            op_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (deq_req) begin
                        if (empty) begin
                            deq_err <= 1'b1;
                        end else begin
                            state <= DEQ_HEAD;
                        end
                    end else if (enq_valid && enq_ready) begin
                        carry <= enq_data;
                        idx   <= '0;
                        state <= empty ? ENQ_WR : ENQ_RD;
                    end
                end
                ENQ_RD: begin
                    state <= ENQ_CMP;
                end
                ENQ_CMP: begin
                    // The smaller of the pair keeps walking toward the tail.
                    if (swap) begin
                        carry <= mem_rdata;
                    end
                    idx   <= idx_nxt;
                    state <= (idx_nxt == count) ? ENQ_WR : ENQ_RD;
                end
                ENQ_WR: begin
                    count   <= count + ONE_C;
                    op_done <= 1'b1;
                    state   <= IDLE;
                end
                DEQ_HEAD: begin
                    state <= DEQ_CAP;
                end
                DEQ_CAP: begin
                    deq_data  <= mem_rdata;
                    deq_valid <= 1'b1;
                    idx       <= ONE_C;
                    if (count > ONE_C) begin
                        state <= DEQ_RD;
                    end else begin
                        count   <= count - ONE_C;
                        op_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DEQ_RD: begin
                    state <= DEQ_SH;
                end
                DEQ_SH: begin
                    idx <= idx_nxt;
                    if (idx_nxt == count) begin
                        count   <= count - ONE_C;
                        op_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= DEQ_RD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pq_controller.md
# pq_controller

Sequencing controller for the QuickQ BRAM-backed priority queue. It owns the single-port BRAM and keeps it sorted in descending order, with the largest key at address 0. An enqueue is a compare-and-swap walk that carries the smaller value forward. A dequeue pops address 0 and shifts the remaining entries up by one. It replaces ad-hoc mode sequencing of the compare/route datapath with one FSM, an occupancy counter and a valid/ready front end.

## Interface
- WIDTH, 32, key width in bits.
- DEPTH, 16, queue capacity in entries (power of two, ≥2).
- ADDR_W, $clog2(DEPTH), BRAM address width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enq_valid  in  1  enqueue request; must be held with enq_data until it is accepted.
- enq_data  in  WIDTH  key to insert.
- enq_ready  out  1  high when state is IDLE and the queue is not full.
- deq_req  in  1  dequeue request; sampled only in IDLE.
- deq_valid  out  1  one-cycle pulse; deq_data holds the popped key.
- deq_data  out  WIDTH  last popped key; holds its value until the next pop.
- deq_err  out  1  one-cycle pulse when deq_req arrives in IDLE while the queue is empty.
- busy  out  1  high whenever state is not IDLE.
- op_done  out  1  one-cycle pulse in the cycle after an enqueue or dequeue completes.
- count  out  ADDR_W+1  number of stored entries.
- full / empty  out  1  count==DEPTH / count==0.
- mem_addr  out  ADDR_W  BRAM address.
- mem_we  out  1  BRAM write enable.
- mem_wdata  out  WIDTH  BRAM write data.
- mem_rdata  in  WIDTH  BRAM read data; valid one cycle after its address is presented (synchronous read).

## Operation
- Registers: state, idx (ADDR_W+1 bits), carry (WIDTH bits), count, deq_data, and the pulse flops.
- mem_* outputs are combinational from state, idx and carry.
- When mem_we=0, mem_addr is the read address.
- FSM states: IDLE, ENQ_RD, ENQ_CMP, ENQ_WR, DEQ_HEAD, DEQ_CAP, DEQ_RD, DEQ_SH.
- **IDLE decisions:**
  - deq_req has priority over enq_valid.
  - deq_req with count>0 goes to DEQ_HEAD.
  - deq_req with count==0 pulses deq_err and stays in IDLE; a pending enq_valid waits one cycle.
  - Otherwise, enq_valid && enq_ready accepts the key: carry<=enq_data, idx<=0. Go to ENQ_RD if count>0, else ENQ_WR.
- **Enqueue:**
  - ENQ_RD: read addr idx.
  - ENQ_CMP, if carry > mem_rdata (strictly greater, unsigned): write carry to addr idx and set carry<=mem_rdata.
  - ENQ_CMP, otherwise: no write.
  - ENQ_CMP exit: idx<=idx+1. Go to ENQ_WR if idx+1==count, else ENQ_RD.
  - ENQ_WR: write carry to addr count; count<=count+1; go to IDLE.
  - Equal keys therefore keep arrival order.
- **Dequeue:**
  - DEQ_HEAD: read addr 0.
  - DEQ_CAP: deq_data<=mem_rdata; deq_valid pulses next cycle; idx<=1. Go to DEQ_RD if count>1, else finish.
  - DEQ_RD: read addr idx.
  - DEQ_SH: write mem_rdata to addr idx-1; idx<=idx+1. Finish when idx+1==count, else go to DEQ_RD.
  - Finish: count<=count-1; go to IDLE.
- Vacated BRAM locations (≥count) are don't-care and are never read.
- Reset mid-operation: the operation is abandoned. The queue is logically empty after reset; BRAM contents are ignored.

## Timing
- **Reset values:**
  - state=IDLE; count=0, empty=1, full=0, enq_ready=1, busy=0.
  - deq_valid=0, deq_err=0, op_done=0, deq_data=0.
  - mem_we=0, mem_addr=0, mem_wdata=0 (carry=0).
- **Enqueue latency:**
  - Acceptance edge is cycle 0.
  - Busy for 2·n+1 cycles, where n is count before the operation.
  - op_done and enq_ready return in the cycle after ENQ_WR.
- **Dequeue latency:**
  - deq_valid is high 2 cycles after the accepting edge.
  - Busy for 2 + 2·(n−1) cycles.
  - op_done in the cycle after the last state.
- Pulses (deq_valid, deq_err, op_done) are exactly one cycle wide.
- enq_ready is 0 throughout busy and while full.
- deq_req is ignored while busy; the requester re-asserts it after op_done.
- count, full and empty update on the edge that leaves ENQ_WR or the final dequeue state.

## Test plan
- **Sorted insert:** from reset, enqueue 5, 9, 3, 9. Required:
  - BRAM[0..3] = 9, 9, 5, 3 and count=4.
  - The 4th enqueue is busy for exactly 7 cycles.
- **Pop order:** from the state above, dequeue four times. Required:
  - deq_data sequence 9, 9, 5, 3, each deq_valid 2 cycles after acceptance.
  - empty=1 at the end.
- **Full:** enqueue 16 keys 1..16. Required:
  - full=1 and enq_ready=0.
  - A 17th enq_valid is held off, never accepted and never written.
  - After one dequeue (deq_data=16), the 17th is accepted.
- **Empty:** deq_req at reset. Required: a deq_err pulse, no BRAM access, count stays 0, no op_done.
- **Simultaneous:** enq_valid(7) and deq_req in the same IDLE cycle with queue {4}. Required:
  - The dequeue returns 4 first.
  - Then 7 is inserted; final count=1, BRAM[0]=7.
- **Reset mid-operation:** assert rst_n=0 during DEQ_SH of a 3-entry queue. Required:
  - All outputs take their reset values immediately, count=0.
  - A subsequent enqueue of 2 lands at BRAM[0].
